// File: rtl/comm_pkg.sv
// Shared symbol/frame geometry and the deserializer state encoding.
package comm_pkg;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned SYMS     = 14;
  localparam int unsigned FRAME_W  = SYM_W * SYMS;
  localparam int unsigned CHAN_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } deser_state_e;

endpackage

// File: rtl/qpsk_symbol_deserializer.sv
// Collects one demodulated symbol per clock into a frame after the channel
// latency has elapsed, then holds it on a valid/ready handshake.
module qpsk_symbol_deserializer #(
  parameter int unsigned SYM_W = comm_pkg::SYM_W,
  parameter int unsigned SYMS  = comm_pkg::SYMS,
  parameter int unsigned LAT   = comm_pkg::CHAN_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SYM_W-1:0]      sym_i,
  output logic [SYM_W*SYMS-1:0] frame_o,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  overrun
);

  import comm_pkg::*;

  localparam int unsigned FW       = SYM_W * SYMS;
  localparam int unsigned CNT_MAX  = (SYMS > LAT + 1) ? SYMS : LAT + 1;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned LAT_LAST = (LAT == 0) ? 0 : LAT - 1;

  deser_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               frame_valid_q, frame_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  // State, counter, frame store and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state, slot write and flag logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (LAT == 0) ? ST_COLLECT : ST_ALIGN;
          cnt_d   = '0;
        end
      end
      ST_ALIGN: begin
        // Symbols still in flight through the channel are ignored here.
        if (cnt_q == CNT_W'(LAT_LAST)) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        frame_d[SYM_W*32'(cnt_q) +: SYM_W] = sym_i;
        if (cnt_q == CNT_W'(SYMS - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (frame_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A start seen while any frame is in progress is dropped and flagged.
    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    frame_valid_d = (state_d == ST_HOLD);
    busy_d        = (state_d != ST_IDLE);
  end

  assign frame_o     = frame_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_qpsk_symbol_deserializer.sv
// Bench for qpsk_symbol_deserializer: default-latency and zero-latency builds.
module tb_qpsk_symbol_deserializer;

  localparam int unsigned NS  = 14;
  localparam int unsigned LAT = 3;
  localparam int unsigned FW  = 28;

  typedef logic [1:0] sym_arr_t [NS];

  typedef struct {
    int         mode;        // 0: k mod 4, 1: constant, 2: random
    logic [1:0] val;
    logic [1:0] garbage;
    int         ready_delay;
    logic [FW-1:0] exp;      // used for modes 0 and 1
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start0;
  logic [1:0]    sym_i, sym0;
  logic [FW-1:0] frame_o, frame0;
  logic          frame_valid, valid0;
  logic          frame_ready, ready0;
  logic          busy, busy0;
  logic          overrun, overrun0;

  int checks = 0;
  int errors = 0;

  qpsk_symbol_deserializer #(.SYM_W(2), .SYMS(NS), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sym_i(sym_i),
    .frame_o(frame_o), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .overrun(overrun)
  );

  qpsk_symbol_deserializer #(.SYM_W(2), .SYMS(NS), .LAT(0)) u_dut_lat0 (
    .clk(clk), .rst(rst), .start(start0), .sym_i(sym0),
    .frame_o(frame0), .frame_valid(valid0), .frame_ready(ready0),
    .busy(busy0), .overrun(overrun0)
  );

  always #5 clk = ~clk;

  // Reference: symbol k lands at bit offset 2k of the frame.
  function automatic logic [FW-1:0] frame_of(input sym_arr_t s);
    logic [FW-1:0] r = '0;
    for (int k = 0; k < NS; k++) r = r + (FW'(s[k]) << (2 * k));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One frame on the LAT=3 instance, starting from IDLE.
  task automatic run_frame(input string nm, input sym_arr_t syms, input logic [1:0] garbage,
                           input int ready_delay, input int restart_t,
                           input bit hold_start, input bit exp_ov);
    logic [FW-1:0] exp = frame_of(syms);
    bit err_busy = 0, err_valid = 0, err_hold = 0;
    @(negedge clk);
    chk({nm, " idle_busy"}, FW'(busy), FW'(0));
    start = 1'b1;
    sym_i = garbage;
    frame_ready = (ready_delay == 0);
    for (int t = 1; t <= int'(LAT + NS); t++) begin
      @(negedge clk);
      start = (t == restart_t);
      sym_i = (t <= int'(LAT)) ? garbage : syms[t - int'(LAT) - 1];
      if (busy !== 1'b1) err_busy = 1;
      if (frame_valid !== 1'b0) err_valid = 1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy_during_frame"}, FW'(err_busy), FW'(0));
    chk({nm, " valid_early"}, FW'(err_valid), FW'(0));
    chk({nm, " valid"}, FW'(frame_valid), FW'(1));
    chk({nm, " frame"}, frame_o, exp);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      if (frame_valid !== 1'b1 || frame_o !== exp || busy !== 1'b1) err_hold = 1;
    end
    if (ready_delay > 0) chk({nm, " hold_stable"}, FW'(err_hold), FW'(0));
    frame_ready = 1'b1;
    start = hold_start;
    @(negedge clk);
    start = 1'b0;
    frame_ready = 1'b0;
    chk({nm, " released_valid"}, FW'(frame_valid), FW'(0));
    chk({nm, " released_busy"}, FW'(busy), FW'(0));
    @(negedge clk);
    chk({nm, " stays_idle"}, FW'(busy), FW'(0));
    chk({nm, " overrun"}, FW'(overrun), FW'(exp_ov));
  endtask

  vec_t     tbl [11];
  sym_arr_t s;

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; sym_i = '0; sym0 = '0;
    frame_ready = 1'b0; ready0 = 1'b0;

    tbl[0] = '{0, 2'd0, 2'd0, 0, 28'h4E4E4E4};
    tbl[1] = '{0, 2'd0, 2'd2, 8, 28'h4E4E4E4};
    tbl[2] = '{1, 2'd0, 2'd3, 1, 28'h0000000};
    tbl[3] = '{1, 2'd3, 2'd0, 2, 28'hFFFFFFF};
    tbl[4] = '{1, 2'd1, 2'd2, 0, 28'h5555555};
    for (int i = 5; i < 11; i++)
      tbl[i] = '{2, 2'd0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), '0};

    repeat (2) @(negedge clk);
    chk("reset frame", frame_o, '0);
    chk("reset valid", FW'(frame_valid), '0);
    chk("reset busy", FW'(busy), '0);
    chk("reset overrun", FW'(overrun), '0);
    chk("reset lat0 frame", frame0, '0);
    rst = 1'b0;

    // Table vectors; constant-pattern rows also cross-check the model.
    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < int'(NS); k++) begin
        case (tbl[v].mode)
          0:       s[k] = 2'(k % 4);
          1:       s[k] = tbl[v].val;
          default: s[k] = 2'($urandom_range(0, 3));
        endcase
      end
      if (tbl[v].mode != 2) chk($sformatf("vec%0d model", v), frame_of(s), tbl[v].exp);
      run_frame($sformatf("vec%0d", v), s, tbl[v].garbage, tbl[v].ready_delay, -1, 1'b0, 1'b0);
    end

    // Start coinciding with the HOLD exit is dropped and flagged.
    for (int k = 0; k < int'(NS); k++) s[k] = 2'(3 - (k % 4));
    run_frame("hold_exit_start", s, 2'd1, 3, -1, 1'b1, 1'b1);

    // Reset mid-COLLECT discards everything.
    @(negedge clk);
    start = 1'b1; sym_i = 2'd3;
    for (int t = 1; t < 10; t++) begin
      @(negedge clk);
      start = 1'b0; sym_i = 2'd3;
    end
    rst = 1'b1;
    #1;
    chk("midrst frame", frame_o, '0);
    chk("midrst valid", FW'(frame_valid), '0);
    chk("midrst busy", FW'(busy), '0);
    chk("midrst overrun", FW'(overrun), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(NS); k++) s[k] = (k % 2 == 0) ? 2'd2 : 2'd0;
    run_frame("after_rst", s, 2'd3, 1, -1, 1'b0, 1'b0);

    // Second start mid-COLLECT: flagged, first frame unaffected.
    for (int k = 0; k < int'(NS); k++) s[k] = 2'(k % 4);
    run_frame("restart_collect", s, 2'd0, 0, 6, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("overrun sticky", FW'(overrun), FW'(1));

    // Zero-latency build collects from the first edge after start.
    @(negedge clk);
    start0 = 1'b1;
    sym0 = 2'd1;
    for (int t = 1; t <= int'(NS); t++) begin
      @(negedge clk);
      start0 = 1'b0;
      sym0 = 2'd1;
      if (t < int'(NS)) begin
        if (t == 1) chk("lat0 busy", FW'(busy0), FW'(1));
      end
    end
    chk("lat0 valid_early", FW'(valid0), FW'(0));
    @(negedge clk);
    chk("lat0 valid", FW'(valid0), FW'(1));
    chk("lat0 frame", frame0, 28'h5555555);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    chk("lat0 released", FW'(valid0), FW'(0));
    chk("lat0 overrun", FW'(overrun0), FW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
